// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// shift_beat_t is the beat layout at the default 48-bit configuration.
package shifter_pkg;

    localparam int unsigned DEF_WIDTH   = 48;
    localparam int unsigned DEF_SHAMT_W = 6;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]   data;
        logic [DEF_SHAMT_W-1:0] shamt;
        shift_dir_e             dir;
        logic                   fill;
        logic                   lost;
    } shift_beat_t;

    // Level 0 is the MSB (largest weight) mux level.
    function automatic int unsigned slice_of_level(input int unsigned level,
                                                   input int unsigned stages,
                                                   input int unsigned shamt_w);
        return (level * stages) / shamt_w;
    endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Valid/ready operand and result channels of the pipelined barrel shifter.
interface shifter_pipe_if #(
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_lost;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
        input  in_ready, out_valid, out_data, out_lost
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
        output in_ready, out_valid, out_data, out_lost
    );
endinterface

// File: rtl/shifter_pipe_slice.sv
// One register slice of the shifter: its share of the mux levels followed by
// a single-entry valid/ready register.
module shifter_pipe_slice
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned SHAMT_W = 6,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned SLICE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  shift_dir_e         i_dir,
    input  logic               i_fill,
    input  logic               i_lost,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic [SHAMT_W-1:0] o_shamt,
    output shift_dir_e         o_dir,
    output logic               o_fill,
    output logic               o_lost
);

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        shift_dir_e         dir;
        logic               fill;
        logic               lost;
    } beat_t;

    // One mux level of weight 2^k; weights of WIDTH or more flush the word.
    function automatic beat_t shift_level(input beat_t b, input int unsigned k, input logic sel);
        beat_t            r;
        logic [WIDTH-1:0] ones;
        int unsigned      n;
        r    = b;
        ones = '1;
        n    = (k < 32) ? (32'd1 << k) : 32'd0;
        if (sel) begin
            if (k >= 32 || n >= WIDTH) begin
                r.data = {WIDTH{b.fill}};
                r.lost = b.lost | (|b.data);
            end else if (b.dir == SHIFT_LEFT) begin
                r.data = b.data << n;
                r.lost = b.lost | (|(b.data >> (WIDTH - n)));
            end else begin
                r.data = (b.data >> n) | (b.fill ? ~(ones >> n) : '0);
                r.lost = b.lost | (|(b.data & ~(ones << n)));
            end
        end
        return r;
    endfunction

    beat_t w_lvl [SHAMT_W+1];
    beat_t r_beat;
    logic  r_valid;
    logic  w_load;

    assign w_lvl[0] = '{data: i_data, shamt: i_shamt, dir: i_dir, fill: i_fill, lost: i_lost};

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
        localparam int unsigned K = SHAMT_W - 1 - i;
        if (slice_of_level(i, STAGES, SHAMT_W) == SLICE) begin : g_mux
            assign w_lvl[i+1] = shift_level(w_lvl[i], K, w_lvl[i].shamt[K]);
        end else begin : g_pass
            assign w_lvl[i+1] = w_lvl[i];
        end
    end

    assign w_load  = !r_valid || i_ready;
    assign o_ready = w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_beat <= w_lvl[SHAMT_W];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_beat.data;
    assign o_shamt = r_beat.shamt;
    assign o_dir   = r_beat.dir;
    assign o_fill  = r_beat.fill;
    assign o_lost  = r_beat.lost;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: STAGES chained slices with a combinational ready
// chain from out_ready back to in_ready.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STAGES  = 2
) (
    input logic           clk,
    input logic           rst,
    shifter_pipe_if.slave io_bus
);

    logic               w_valid [STAGES+1];
    logic               w_ready [STAGES+1];
    logic [WIDTH-1:0]   w_data  [STAGES+1];
    logic [SHAMT_W-1:0] w_shamt [STAGES+1];
    shift_dir_e         w_dir   [STAGES+1];
    logic               w_fill  [STAGES+1];
    logic               w_lost  [STAGES+1];
    logic               w_unused;

    assign w_valid[0]      = io_bus.in_valid;
    assign io_bus.in_ready = w_ready[0];
    assign w_data[0]       = io_bus.in_data;
    assign w_shamt[0]      = io_bus.in_shamt;
    assign w_dir[0]        = shift_dir_e'(io_bus.in_dir);
    assign w_fill[0]       = io_bus.in_dir & io_bus.in_arith & io_bus.in_data[WIDTH-1];
    assign w_lost[0]       = 1'b0;

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        shifter_pipe_slice #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .STAGES  (STAGES),
            .SLICE   (s)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[s]),
            .o_ready (w_ready[s]),
            .i_data  (w_data[s]),
            .i_shamt (w_shamt[s]),
            .i_dir   (w_dir[s]),
            .i_fill  (w_fill[s]),
            .i_lost  (w_lost[s]),
            .o_valid (w_valid[s+1]),
            .i_ready (w_ready[s+1]),
            .o_data  (w_data[s+1]),
            .o_shamt (w_shamt[s+1]),
            .o_dir   (w_dir[s+1]),
            .o_fill  (w_fill[s+1]),
            .o_lost  (w_lost[s+1])
        );
    end

    assign w_ready[STAGES]  = io_bus.out_ready;
    assign io_bus.out_valid = w_valid[STAGES];
    assign io_bus.out_data  = w_data[STAGES];
    assign io_bus.out_lost  = w_lost[STAGES];

    // Side-band fields are spent once the last level has been applied.
    assign w_unused = ^{w_shamt[STAGES], 1'(w_dir[STAGES]), w_fill[STAGES]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench: directed cases on a 2-slice pipe, random sweeps on 1/3/6 slices.
module tb_shifter_pipe;

    localparam int unsigned W  = 48;
    localparam int unsigned SW = 6;

    typedef struct packed {
        logic [W-1:0] data;
        logic         lost;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sweep_go = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_acc0 = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-level reference: every destination bit picks its source or fill.
    function automatic exp_t model(input logic [W-1:0] d, input int amt, input logic dir,
                                   input logic arith);
        exp_t e;
        logic fill;
        int   src;
        int   dst;
        fill   = dir & arith & d[W-1];
        e.data = '0;
        e.lost = 1'b0;
        for (int j = 0; j < int'(W); j++) begin
            src = dir ? j + amt : j - amt;
            e.data[j] = (src >= 0 && src < int'(W)) ? d[src] : fill;
            dst = dir ? j - amt : j + amt;
            if (dst < 0 || dst >= int'(W)) e.lost = e.lost | d[j];
        end
        return e;
    endfunction

    shifter_pipe_if #(.WIDTH(W), .SHAMT_W(SW)) bus0 ();
    shifter_pipe #(.WIDTH(W), .SHAMT_W(SW), .STAGES(2)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus0)
    );

    exp_t q0[$];

    // Sends one beat to the 2-slice pipe; call at posedge+1, returns at posedge+1.
    task automatic send0(input logic [W-1:0] d, input int amt, input logic dir, input logic arith,
                         input logic [W-1:0] ed, input logic el);
        int unsigned waitc;
        logic        acc;
        exp_t        e;
        waitc         = 0;
        acc           = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        bus0.in_shamt = SW'(amt);
        bus0.in_dir   = dir;
        bus0.in_arith = arith;
        while (!acc && waitc < 100) begin
            @(negedge clk);
            if (bus0.in_ready) acc = 1'b1;
            else waitc++;
        end
        check_eq("s2_accept_in_time", 64'(acc), 64'd1);
        if (acc) begin
            e.data = ed;
            e.lost = el;
            q0.push_back(e);
            n_acc0++;
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    // Output monitor for the 2-slice pipe, including stall stability.
    initial begin : mon0
        exp_t         e;
        logic         stalled;
        logic [W-1:0] held_data;
        logic         held_lost;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (bus0.out_valid && bus0.out_ready) begin
                    check_eq("s2_beat_expected", 64'(q0.size() > 0), 64'd1);
                    if (q0.size() > 0) begin
                        e = q0.pop_front();
                        check_eq("s2_data", 64'(bus0.out_data), 64'(e.data));
                        check_eq("s2_lost", 64'(bus0.out_lost), 64'(e.lost));
                    end
                end
                if (stalled) begin
                    check_eq("s2_stall_data", 64'(bus0.out_data), 64'(held_data));
                    check_eq("s2_stall_lost", 64'(bus0.out_lost), 64'(held_lost));
                end
                stalled   = bus0.out_valid && !bus0.out_ready;
                held_data = bus0.out_data;
                held_lost = bus0.out_lost;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned ST = (g == 0) ? 1 : (g == 1) ? 3 : 6;

        shifter_pipe_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
        shifter_pipe #(.WIDTH(W), .SHAMT_W(SW), .STAGES(ST)) dut (
            .clk    (clk),
            .rst    (rst),
            .io_bus (bus)
        );

        exp_t q[$];
        logic done = 1'b0;
        logic tput = 1'b0;

        initial begin : rdy
            bus.out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                if (sweep_go) bus.out_ready = tput ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end

        initial begin : drv
            logic [W-1:0] d;
            int           amt;
            logic         dir;
            logic         arith;
            logic         acc;
            int unsigned  waitc;
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            bus.in_shamt = '0;
            bus.in_dir   = 1'b0;
            bus.in_arith = 1'b0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int i = 0; i < 300; i++) begin
                d = W'({$urandom(), $urandom()});
                if ($urandom_range(0, 3) == 0) d[W-1] = 1'b1;
                amt = int'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) amt = 46 + int'($urandom_range(0, 3));
                dir   = 1'($urandom_range(0, 1));
                arith = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                bus.in_shamt = SW'(amt);
                bus.in_dir   = dir;
                bus.in_arith = arith;
                acc   = 1'b0;
                waitc = 0;
                while (!acc && waitc < 200) begin
                    @(negedge clk);
                    if (bus.in_ready) acc = 1'b1;
                    else waitc++;
                end
                check_eq($sformatf("st%0d_accept_in_time", ST), 64'(acc), 64'd1);
                if (acc) q.push_back(model(d, amt, dir, arith));
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
            tput  = 1'b1;
            waitc = 0;
            while (q.size() != 0 && waitc < 200) begin
                @(posedge clk);
                waitc++;
            end
            #1;
            for (int i = 0; i < 20; i++) begin
                d            = W'({$urandom(), $urandom()});
                amt          = int'($urandom_range(0, 63));
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                bus.in_shamt = SW'(amt);
                bus.in_dir   = 1'b1;
                bus.in_arith = 1'b1;
                @(negedge clk);
                check_eq($sformatf("st%0d_tput_in_ready", ST), 64'(bus.in_ready), 64'd1);
                if (bus.in_ready) q.push_back(model(d, amt, 1'b1, 1'b1));
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b0;
            waitc = 0;
            while (q.size() != 0 && waitc < 200) begin
                @(posedge clk);
                waitc++;
            end
            check_eq($sformatf("st%0d_drained", ST), 64'(q.size()), 64'd0);
            done = 1'b1;
        end

        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst && bus.out_valid && bus.out_ready) begin
                    check_eq($sformatf("st%0d_beat_expected", ST), 64'(q.size() > 0), 64'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check_eq($sformatf("st%0d_data", ST), 64'(bus.out_data), 64'(e.data));
                        check_eq($sformatf("st%0d_lost", ST), 64'(bus.out_lost), 64'(e.lost));
                    end
                end
            end
        end
    end

    initial begin : main
        int unsigned lat;
        int unsigned guard;
        int unsigned base;
        logic        bp_done;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.in_shamt  = '0;
        bus0.in_dir    = 1'b0;
        bus0.in_arith  = 1'b0;
        bus0.out_ready = 1'b1;
        bp_done        = 1'b0;

        #1 rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("rst_out_data", 64'(bus0.out_data), 64'd0);
        check_eq("rst_out_lost", 64'(bus0.out_lost), 64'd0);
        check_eq("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // First-beat latency
        send0(48'h0000_0000_0001, 47, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0);
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("s2_latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;

        // Directed shifts, back to back
        send0(48'h8000_0000_0003, 1, 1'b1, 1'b1, 48'hC000_0000_0001, 1'b1);
        send0(48'h8000_0000_0003, 1, 1'b1, 1'b0, 48'h4000_0000_0001, 1'b1);
        send0(48'hFFFF_FFFF_FFFF, 63, 1'b1, 1'b0, 48'h0000_0000_0000, 1'b1);
        send0(48'hFFFF_FFFF_FFFF, 63, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        send0(48'h0000_0000_0000, 48, 1'b0, 1'b0, 48'h0000_0000_0000, 1'b0);
        send0(48'h0000_0000_0123, 0, 1'b0, 1'b1, 48'h0000_0000_0123, 1'b0);
        send0(48'h8000_0000_0000, 47, 1'b1, 1'b0, 48'h0000_0000_0001, 1'b0);
        send0(48'h8000_0000_00F0, 4, 1'b1, 1'b1, 48'hF800_0000_000F, 1'b0);
        send0(48'hF000_0000_0001, 4, 1'b0, 1'b0, 48'h0000_0000_0010, 1'b1);
        send0(48'h0000_0000_0001, 48, 1'b1, 1'b0, 48'h0000_0000_0000, 1'b1);
        send0(48'h8000_0000_0000, 1, 1'b0, 1'b0, 48'h0000_0000_0000, 1'b1);
        send0(48'h8000_0000_0000, 63, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        guard = 0;
        while (q0.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("s2_directed_drained", 64'(q0.size()), 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: four beats against a stalled consumer
        base = n_acc0;
        bus0.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send0(48'h0000_0000_0001, k, 1'b0, 1'b0, 48'h0000_0000_0001 << k, 1'b0);
                end
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(negedge clk);
        check_eq("bp_accepts_while_stalled", 64'(n_acc0 - base), 64'd2);
        check_eq("bp_in_ready_low", 64'(bus0.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("bp_drain_valid", 64'(bus0.out_valid), 64'd1);
        end
        guard = 0;
        while (!(bp_done && q0.size() == 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("bp_all_drained", 64'(bp_done && q0.size() == 0), 64'd1);
        @(posedge clk);
        #1;

        // Reset pulse with two beats in flight
        send0(48'h0000_0000_00AA, 3, 1'b0, 1'b0, 48'h0000_0000_0550, 1'b0);
        send0(48'h0000_0000_00BB, 3, 1'b0, 1'b0, 48'h0000_0000_05D8, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("midrst_out_data", 64'(bus0.out_data), 64'd0);
        check_eq("midrst_out_lost", 64'(bus0.out_lost), 64'd0);
        q0.delete();
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("midrst_no_stale", 64'(bus0.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send0(48'h0000_0000_0F0F, 8, 1'b1, 1'b0, 48'h0000_0000_000F, 1'b1);
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("midrst_latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;

        // Random sweeps on the other depths
        sweep_go = 1'b1;
        guard = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        check_eq("sweep_finished", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done),
                 64'd1);
        check_eq("s2_final_empty", 64'(q0.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter for the multiplier and normalisation datapaths. Shifts left or right, logical or arithmetic, by any amount from 0 to 2^SHAMT_W-1, including amounts of WIDTH or more. Produces a sticky "lost bits" flag for rounding. A configurable number of register slices sits between the log-depth mux levels, and valid/ready handshakes with full backpressure connect the slices.

## Interface
- WIDTH, 48: data width in bits; must be at least 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width; must be at least $clog2(WIDTH).
- STAGES, 2: number of register slices, 1..SHAMT_W; this is also the latency.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: reset, asynchronous, active-high.
- in_valid  in  1: input beat is present.
- in_ready  out  1: the block accepts the beat this cycle.
- in_data  in  WIDTH: operand.
- in_shamt  in  SHAMT_W: shift amount, unsigned.
- in_dir  in  1: 0 = left, 1 = right.
- in_arith  in  1: right shift fills with in_data[WIDTH-1]; ignored for left shifts.
- out_valid  out  1: result beat is present.
- out_ready  in  1: the consumer takes the beat this cycle.
- out_data  out  WIDTH: shifted result.
- out_lost  out  1: OR of every input bit shifted off the end of the word.

## Operation
- Fill bit: 0 for all left shifts and for logical right shifts; in_data[WIDTH-1] for arithmetic right shifts.
- Mux levels:
  - SHAMT_W levels, applied MSB first.
  - Level k (weight 2^k) shifts by 2^k when shamt[k]=1.
  - Each level ORs the bits it shifts out into a running lost flag.
  - Fill bit, dir, arith and the remaining shamt bits travel alongside the data.
- Saturation:
  - Any level with 2^k ≥ WIDTH replaces the whole word with fill.
  - On that replacement, lost |= OR of the current word.
  - Result: shamt ≥ WIDTH gives all-fill, and lost = OR(in_data) restricted to non-fill-significant bits as shifted out. Practically this is OR(in_data) for logical and left shifts.
- Arithmetic right lost flag: OR of the discarded low bits only. Sign copies never count as lost.
- Level-to-slice assignment:
  - Level index i = 0 is the MSB level, i = SHAMT_W-1 the LSB level.
  - Level i belongs to slice floor(i*STAGES/SHAMT_W).
  - Each slice registers its output.
- Slice handshake:
  - Each slice holds one valid bit.
  - Slice s may load when its valid is 0 or slice s+1 (the output port for the last slice) takes its beat this cycle.
  - in_ready = load-enable of slice 0.
- Ready chain: the ready chain is combinational from out_ready back to in_ready. With no stalls, the pipe sustains 1 beat per cycle.
- Data path on transfers:
  - A beat is accepted when in_valid && in_ready.
  - Data registers load only on accept or on advance; they hold during stall.
- Ordering: beats are never dropped, duplicated or reordered.

## Timing
- Latency: a beat accepted at edge n appears on out_* after edge n+STAGES-1, i.e. valid in the cycle after STAGES edges counting the accept edge. Equivalently, out_valid rises STAGES cycles after the accept cycle.
- Capacity: STAGES beats in flight.
- Reset value of every output:
  - in_ready: 1, after the first evaluation following reset (combinational from empty slices).
  - out_valid: 0.
  - out_data: 0.
  - out_lost: 0.
- Reset internals: all slice valid bits and data/flag registers clear asynchronously on rst. Beats in flight are discarded.
- Stall: out_data and out_lost stay stable while out_valid && !out_ready.
- Simultaneous events: when the last slice drains and a new beat is accepted in the same cycle, both occur. No bubble is inserted.
- Input-side inputs may change freely while in_ready = 0. They are sampled only on accept.

## Structure
- Package shifter_pkg holds:
  - Enum shift_dir_e {SHIFT_LEFT = 0, SHIFT_RIGHT = 1}.
  - Function for the level-to-slice mapping.
  - Packed struct shift_beat_t: data, remaining shamt, dir, fill, lost.
- Sub-module shifter_pipe_slice: one register slice.
  - Contains its mux levels (generate loop over the assigned level range) and the valid/ready register.
  - Top level generates STAGES instances and chains them.

## Test plan
- WIDTH=48, STAGES=2, left shift 48'h0000_0000_0001 by 47 → out_data 48'h8000_0000_0000, out_lost 0; out_valid 2 cycles after accept.
- Arithmetic right shift 48'h8000_0000_0003 by 1 → out_data 48'hC000_0000_0001, out_lost 1. Logical right shift of the same operand → 48'h4000_0000_0001, out_lost 1.
- shamt=63 right shift of 48'hFFFF_FFFF_FFFF:
  - Logical → out_data 0, out_lost 1.
  - Arithmetic → 48'hFFFF_FFFF_FFFF, out_lost 1.
  - Left shift by 48 of 48'h0 → out_data 0, out_lost 0.
- Backpressure: 4 back-to-back beats, out_ready=0 for 6 cycles.
  - in_ready drops after 2 accepts.
  - After out_ready=1, all 4 results emerge in order, 1 per cycle, unchanged during the stall.
- Reset mid-flight: 2 beats in flight, pulse rst for less than 1 cycle.
  - out_valid drops to 0 immediately; out_data is 0.
  - No stale beat appears after release.
  - The next accepted beat has normal latency.
- Random sweep, STAGES ∈ {1,3,6}, random out_ready against a reference model → every result and lost flag matches; throughput is 1/cycle when out_ready is held at 1.
